// File: rtl/tinker_fetch_unit.sv
// ---------------------------------------------------------------------------
// tinker_fetch_unit
//
// Instruction fetch stage for tinker_core. Owns the program counter, issues
// one 32-bit instruction read at a time to instruction memory over a req/ack
// handshake, and buffers returned words (with their PCs) in a small prefetch
// FIFO that feeds the decoder through a valid/ready handshake. A redirect
// from execute flushes the FIFO and restarts fetch at the new PC.
//
// Ports:
//   clk            in   1   clock, all state updates on the rising edge
//   reset_n        in   1   asynchronous active-low reset
//   imem_req       out  1   read request to instruction memory
//   imem_addr      out  64  byte address of the requested word (bits [1:0] = 0)
//   imem_ack       in   1   memory accepts the request and returns data now
//   imem_rdata     in   32  instruction word, sampled only on a transfer
//   redirect_valid in   1   flush the FIFO and restart fetch
//   redirect_pc    in   64  restart PC, bits [1:0] ignored
//   inst_valid     out  1   FIFO head holds an instruction
//   inst_ready     in   1   decoder consumes the head this cycle
//   inst_out       out  32  instruction at the FIFO head
//   inst_pc        out  64  PC of the instruction at the FIFO head
// ---------------------------------------------------------------------------
module tinker_fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h2000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // REQ     : normal fetching, request raised whenever a FIFO slot is free.
    // DISCARD : a request issued before a redirect is still outstanding; its
    //           data must be swallowed when it finally completes.
    typedef enum logic [0:0] {
        ST_REQ     = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Held low through reset and set on the first edge afterwards so that
    // imem_req only rises once the block is actually running.
    logic               r_run;
    logic [63:0]        r_fetch_pc;
    // Address of the request that was in flight when we entered DISCARD;
    // the memory handshake requires it to stay on imem_addr until the ack.
    logic [63:0]        r_stale_addr;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;

    logic [31:0]        r_mem_inst [FIFO_DEPTH];
    logic [63:0]        r_mem_pc   [FIFO_DEPTH];

    logic               w_slot_free;
    logic               w_req;
    logic [63:0]        w_addr;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;
    logic [63:0]        w_redirect_target;

    assign w_slot_free       = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_valid           = (r_count != '0);
    // A redirect wipes the FIFO in the same edge, so a pop is meaningless.
    assign w_pop             = w_valid && inst_ready && !redirect_valid;
    assign w_redirect_target = redirect_pc & ~64'd3;

    // -----------------------------------------------------------------------
    // Fetch FSM: next state and handshake outputs
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_addr       = r_fetch_pc;
        w_push       = 1'b0;

        case (r_state)
            ST_REQ: begin
                // The slot is reserved at request time: count cannot grow
                // while the request is pending, so the ack always fits.
                w_req  = r_run && w_slot_free;
                w_addr = r_fetch_pc;
                if (w_req && imem_ack) begin
                    // A same-cycle redirect drops the returned word.
                    w_push = !redirect_valid;
                end else if (w_req && redirect_valid) begin
                    w_state_next = ST_DISCARD;
                end
            end

            ST_DISCARD: begin
                w_req  = 1'b1;
                w_addr = r_stale_addr;
                // The stale request completes here; further redirects only
                // move fetch_pc. If an ack coincides with another redirect
                // the old request is still done, so fetch resumes normally.
                if (imem_ack) begin
                    w_state_next = ST_REQ;
                end
            end

            default: begin
                w_state_next = ST_REQ;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, PC and FIFO bookkeeping
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_REQ;
            r_run        <= 1'b0;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= RESET_PC;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;

            // While in REQ the address on the bus is fetch_pc; remember it
            // so that entering DISCARD keeps presenting the same address.
            if (r_state == ST_REQ) begin
                r_stale_addr <= r_fetch_pc;
            end

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_push) begin
                    r_fetch_pc <= r_fetch_pc + 64'd4;
                    r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // FIFO storage: no reset needed, occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign imem_req   = w_req;
    assign imem_addr  = w_addr;
    assign inst_valid = w_valid;
    // Head data is forced to zero when empty so stale storage never shows.
    assign inst_out   = w_valid ? r_mem_inst[r_rd_ptr] : 32'd0;
    assign inst_pc    = w_valid ? r_mem_pc[r_rd_ptr]   : 64'd0;

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_tinker_fetch_unit
//
// Scoreboard bench for tinker_fetch_unit. A stimulus process drives memory
// acks, decoder ready and redirects, and keeps a reference model of the
// fetch side (next PC, whether an outstanding request is stale) plus a queue
// of the instructions the decoder should see. A separate monitor process
// compares the DUT's handshake outputs and FIFO head against that model.
// ---------------------------------------------------------------------------
module tb_tinker_fetch_unit;

    localparam logic [63:0] RESET_PC   = 64'h2000;
    localparam int          FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;

    tinker_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    // Reference model state
    ent_t        exp_q[$];      // instructions the decoder should see, in order
    ent_t        pend;          // word accepted at the coming edge
    logic        pend_v;
    logic        last_redir;
    logic [63:0] exp_pc;        // where the next real request goes
    logic        discard;       // outstanding request belongs to an old stream
    logic [63:0] stale_addr;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        armed;         // monitor has a fresh expectation this cycle

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus. Inputs are driven 1 unit after the falling edge
    // and take effect on the following rising edge.
    task automatic step(input logic a, input logic [31:0] d, input logic rdy,
                        input logic rv, input logic [63:0] rp);
        logic xfer;
        @(negedge clk);
        #1;
        // Apply the outcome of the previous edge to the expected FIFO.
        if (last_redir) exp_q.delete();
        if (pend_v) exp_q.push_back(pend);
        pend_v     = 1'b0;
        last_redir = rv;

        exp_req  = discard || (exp_q.size() < FIFO_DEPTH);
        exp_addr = discard ? stale_addr : exp_pc;

        // Keep redirect and the stale ack apart; that overlap is left open.
        if (rv && discard) a = 1'b0;

        imem_ack       = a;
        imem_rdata     = d;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_pc    = rp;

        xfer = exp_req && a;
        if (rv) begin
            if (!discard && exp_req && !a) begin
                discard    = 1'b1;
                stale_addr = exp_pc;
            end
            exp_pc = {rp[63:2], 2'b00};
        end else if (xfer) begin
            if (discard) begin
                discard = 1'b0;
            end else begin
                pend.inst = d;
                pend.pc   = exp_pc;
                pend_v    = 1'b1;
                exp_pc    = exp_pc + 64'd4;
            end
        end
        armed = 1'b1;
        $display("cyc t=%0t ack=%0b rdy=%0b redir=%0b rpc=%h exp_req=%0b exp_addr=%h qsize=%0d",
                 $time, a, rdy, rv, rp, exp_req, exp_addr, exp_q.size());
    endtask

    // Reset pulse that starts away from the clock edge, so the asynchronous
    // drop of the outputs can be observed without any clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset_n        = 1'b0;
        imem_ack       = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        armed          = 1'b0;
        #1;
        chk("rst_async_req", {63'd0, imem_req}, 64'd0);
        chk("rst_async_valid", {63'd0, inst_valid}, 64'd0);
        @(negedge clk);
        #1;
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);
        chk("rst_inst_out", {32'd0, inst_out}, 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        reset_n = 1'b1;
        exp_q.delete();
        pend_v     = 1'b0;
        last_redir = 1'b0;
        discard    = 1'b0;
        exp_pc     = RESET_PC;
        stale_addr = RESET_PC;
        #2;
        chk("release_req_before_edge", {63'd0, imem_req}, 64'd0);
    endtask

    // Monitor: compares the DUT against the model just before the edge that
    // the current inputs will act on.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (armed) begin
                armed = 1'b0;
                chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
                chk("imem_addr", imem_addr, exp_addr);
                chk("inst_valid", {63'd0, inst_valid}, {63'd0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    chk("inst_out", {32'd0, inst_out}, {32'd0, exp_q[0].inst});
                    chk("inst_pc", inst_pc, exp_q[0].pc);
                    if (inst_ready && !redirect_valid) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic        rv;
        logic [63:0] rp;
        armed      = 1'b0;
        pend_v     = 1'b0;
        last_redir = 1'b0;
        discard    = 1'b0;
        exp_pc     = RESET_PC;
        stale_addr = RESET_PC;

        // Streaming with zero-wait memory and an always-ready decoder.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, $urandom, 1'b1, 1'b0, 64'd0);

        // Decoder stalled: four words fill the FIFO, then one pop re-opens it.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, 1'b0, 64'd0);
        step(1'b1, $urandom, 1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 64'd0);

        // Slow ack on 0x2004 with a redirect to 0x3002 during the wait.
        do_reset();
        step(1'b1, $urandom, 1'b0, 1'b0, 64'd0);
        step(1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        step(1'b0, $urandom, 1'b0, 1'b1, 64'h3002);
        step(1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        step(1'b1, $urandom, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, 1'b0, 64'd0);

        // Full FIFO: redirect to 0x4000 with ack and pop in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 64'd0);
        step(1'b1, $urandom, 1'b1, 1'b1, 64'h4000);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, 1'b0, 64'd0);

        // PC wrap at the top of the address space.
        do_reset();
        step(1'b1, $urandom, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, 1'b0, 64'd0);

        // Reset while a request waits with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 2; i++) step(1'b0, $urandom, 1'b0, 1'b0, 64'd0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, 1'b0, 64'd0);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if (n % 400 == 399) do_reset();
            rv = ($urandom_range(0, 99) < 6);
            rp = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0)
                rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50, rv, rp);
        end

        // Let the monitor consume the final expectation.
        @(negedge clk);
        #5;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
